// File: rtl/sram_like_arbiter_if.sv
// ============================================================================
//  Module : sram_like_arbiter_if
//  Brief  : One sram-like request/response channel (req/addr_ok, data_ok).
//           The master modport issues requests and the slave modport answers.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

`default_nettype wire

// File: rtl/sram_like_arbiter.sv
// ============================================================================
//  Module : sram_like_arbiter
//  Brief  : Shares one sram-like memory port between the instruction-fetch
//           and data masters. Data has priority, and a streak limit stops it
//           from starving fetch. A small owner FIFO routes each in-order
//           response back to the master that issued the request.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_like_arbiter #(
  parameter int OUTSTANDING = 4,   // power of 2, >= 2
  parameter int STREAK_MAX  = 4    // >= 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  sram_like_arbiter_if.slave   inst,
  sram_like_arbiter_if.slave   data,
  sram_like_arbiter_if.master  mem
);

  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam int STK_W = $clog2(STREAK_MAX + 1);

  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       head_q,  head_d;
  logic [PTR_W-1:0]       tail_q,  tail_d;
  logic [OUTSTANDING-1:0] owner_q, owner_d;   // 1 = data, 0 = inst
  logic [STK_W-1:0]       streak_q, streak_d;

  logic w_full;
  logic w_force_inst;
  logic w_grant_data;
  logic w_grant_inst;
  logic w_mem_req;
  logic w_accept;
  logic w_pop;
  logic w_resp_data;
  logic w_resp_inst;

  // Arbitration, accept and response routing; every output is forced low in reset.
  always_comb begin
    w_full       = (count_q == CNT_W'(OUTSTANDING));
    w_force_inst = inst.req && (streak_q == STK_W'(STREAK_MAX));
    w_grant_data = data.req && !w_force_inst;
    w_grant_inst = !w_grant_data && inst.req;
    // Full is based on registered count only, so a pop never feeds mem_req.
    w_mem_req    = resetn && (inst.req || data.req) && !w_full;
    w_accept     = w_mem_req && mem.addr_ok;
    // Responses with nothing outstanding (e.g. in flight across a reset) are dropped.
    w_pop        = resetn && mem.data_ok && (count_q != '0);
    w_resp_data  = w_pop && owner_q[head_q];
    w_resp_inst  = w_pop && !owner_q[head_q];
  end

  // Request mux toward memory from whichever master holds the grant.
  always_comb begin
    mem.req   = w_mem_req;
    mem.wr    = 1'b0;
    mem.size  = 2'd0;
    mem.addr  = 32'd0;
    mem.wdata = 32'd0;
    if (resetn && w_grant_data) begin
      mem.wr    = data.wr;
      mem.size  = data.size;
      mem.addr  = data.addr;
      mem.wdata = data.wdata;
    end else if (resetn && w_grant_inst) begin
      mem.wr    = inst.wr;
      mem.size  = inst.size;
      mem.addr  = inst.addr;
      mem.wdata = inst.wdata;
    end
  end

  // Handshake and response outputs back to the two masters.
  always_comb begin
    data.addr_ok = w_accept && w_grant_data;
    inst.addr_ok = w_accept && w_grant_inst;
    data.data_ok = w_resp_data;
    inst.data_ok = w_resp_inst;
    data.rdata   = w_resp_data ? mem.rdata : 32'd0;
    inst.rdata   = w_resp_inst ? mem.rdata : 32'd0;
  end

  // Next-state for the owner FIFO and the data-grant streak counter.
  always_comb begin
    count_d  = count_q;
    head_d   = head_q;
    tail_d   = tail_q;
    owner_d  = owner_q;
    streak_d = streak_q;

    if (w_accept) begin
      owner_d[tail_q] = w_grant_data;
      tail_d          = tail_q + 1'b1;
    end
    if (w_pop) begin
      head_d = head_q + 1'b1;
    end
    if (w_accept && !w_pop) begin
      count_d = count_q + 1'b1;
    end else if (!w_accept && w_pop) begin
      count_d = count_q - 1'b1;
    end

    if (!inst.req) begin
      streak_d = '0;
    end else if (w_accept && w_grant_inst) begin
      streak_d = '0;
    end else if (w_accept && w_grant_data && (streak_q != STK_W'(STREAK_MAX))) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // State registers, flushed by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      owner_q  <= '0;
      streak_q <= '0;
    end else begin
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
// ============================================================================
//  Module : tb_sram_like_arbiter
//  Brief  : Directed self-checking bench for sram_like_arbiter.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sram_like_arbiter;

  logic clk;
  logic resetn;
  int   tests;
  int   fails;

  sram_like_arbiter_if inst_if ();
  sram_like_arbiter_if data_if ();
  sram_like_arbiter_if mem_if  ();

  sram_like_arbiter #(
    .OUTSTANDING (4),
    .STREAK_MAX  (4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .inst   (inst_if),
    .data   (data_if),
    .mem    (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; inputs change here, checks follow after #1.
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_d;
    tests = 0;
    fails = 0;
    resetn = 1'b0;
    inst_if.req = 0; inst_if.wr = 0; inst_if.size = 2'd2; inst_if.addr = 0; inst_if.wdata = 0;
    data_if.req = 0; data_if.wr = 0; data_if.size = 2'd2; data_if.addr = 0; data_if.wdata = 0;
    mem_if.addr_ok = 0; mem_if.data_ok = 0; mem_if.rdata = 0;

    // Reset: outputs stay low even with a request and memory handshakes asserted
    nxt();
    inst_if.req = 1; inst_if.addr = 32'h1fc00000; mem_if.addr_ok = 1; mem_if.data_ok = 1;
    mem_if.rdata = 32'hdeadbeef;
    #1;
    chk("rst_mem_req",      mem_if.req,      0);
    chk("rst_mem_addr",     mem_if.addr,     0);
    chk("rst_inst_addr_ok", inst_if.addr_ok, 0);
    chk("rst_inst_data_ok", inst_if.data_ok, 0);
    chk("rst_inst_rdata",   inst_if.rdata,   0);
    mem_if.data_ok = 0; mem_if.rdata = 0;

    // 1: single fetch, response one cycle later
    nxt();
    resetn = 1;
    #1;
    chk("t1_mem_req",      mem_if.req,      1);
    chk("t1_mem_addr",     mem_if.addr,     32'h1fc00000);
    chk("t1_inst_addr_ok", inst_if.addr_ok, 1);
    chk("t1_data_addr_ok", data_if.addr_ok, 0);
    nxt();
    inst_if.req = 0; mem_if.addr_ok = 0; mem_if.data_ok = 1; mem_if.rdata = 32'h3c010000;
    #1;
    chk("t1_inst_data_ok", inst_if.data_ok, 1);
    chk("t1_inst_rdata",   inst_if.rdata,   32'h3c010000);
    chk("t1_data_data_ok", data_if.data_ok, 0);
    chk("t1_data_rdata",   data_if.rdata,   0);
    chk("t1_mem_req_idle", mem_if.req,      0);

    // 2: simultaneous requests, data wins, inst next cycle
    nxt();
    mem_if.data_ok = 0; mem_if.rdata = 0; mem_if.addr_ok = 1;
    inst_if.req = 1; inst_if.addr = 32'h1fc00000;
    data_if.req = 1; data_if.addr = 32'h80001000;
    #1;
    chk("t2_data_addr_ok", data_if.addr_ok, 1);
    chk("t2_inst_addr_ok", inst_if.addr_ok, 0);
    chk("t2_mem_addr_d",   mem_if.addr,     32'h80001000);
    nxt();
    data_if.req = 0;
    #1;
    chk("t2_inst_addr_ok2", inst_if.addr_ok, 1);
    chk("t2_mem_addr_i",    mem_if.addr,     32'h1fc00000);
    nxt();
    inst_if.req = 0; mem_if.addr_ok = 0; mem_if.data_ok = 1; mem_if.rdata = 32'h00000011;
    #1;
    chk("t2_resp0_data_ok", data_if.data_ok, 1);
    chk("t2_resp0_rdata",   data_if.rdata,   32'h00000011);
    chk("t2_resp0_inst_ok", inst_if.data_ok, 0);
    nxt();
    mem_if.rdata = 32'h00000022;
    #1;
    chk("t2_resp1_inst_ok", inst_if.data_ok, 1);
    chk("t2_resp1_rdata",   inst_if.rdata,   32'h00000022);
    chk("t2_resp1_data_ok", data_if.data_ok, 0);

    // 3: streak limit, 4 data grants then a forced inst grant
    nxt();
    mem_if.rdata = 0; mem_if.addr_ok = 1; mem_if.data_ok = 1;
    inst_if.req = 1; inst_if.addr = 32'h1fc00040;
    data_if.req = 1; data_if.addr = 32'h80002000; data_if.wr = 1; data_if.wdata = 32'hcafef00d;
    exp_d = 8'b1110_1111;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) nxt();
      #1;
      chk($sformatf("t3_data_addr_ok_%0d", i), data_if.addr_ok, exp_d[i]);
      chk($sformatf("t3_inst_addr_ok_%0d", i), inst_if.addr_ok, !exp_d[i]);
      chk($sformatf("t3_mem_wr_%0d", i),       mem_if.wr,       exp_d[i]);
      chk($sformatf("t3_mem_wdata_%0d", i),    mem_if.wdata,    exp_d[i] ? 32'hcafef00d : 32'h0);
    end
    nxt();
    inst_if.req = 0; data_if.req = 0; data_if.wr = 0; data_if.wdata = 0; mem_if.addr_ok = 0;
    #1;
    chk("t3_drain_data_ok", data_if.data_ok, 1);

    // 4: fill with no responses; full blocks, a pop re-enables next cycle
    nxt();
    mem_if.data_ok = 0; mem_if.addr_ok = 1; inst_if.req = 1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) nxt();
      #1;
      chk($sformatf("t4_inst_addr_ok_%0d", i), inst_if.addr_ok, (i < 4) ? 1 : 0);
      chk($sformatf("t4_mem_req_%0d", i),      mem_if.req,      (i < 4) ? 1 : 0);
    end
    nxt();
    mem_if.data_ok = 1; mem_if.rdata = 32'h55;
    #1;
    chk("t4_pop_inst_ok",  inst_if.data_ok, 1);
    chk("t4_pop_mem_req",  mem_if.req,      0);
    chk("t4_pop_addr_ok",  inst_if.addr_ok, 0);
    nxt();
    mem_if.data_ok = 0;
    #1;
    chk("t4_resume_mem_req", mem_if.req,      1);
    chk("t4_resume_addr_ok", inst_if.addr_ok, 1);
    nxt();
    inst_if.req = 0; mem_if.addr_ok = 0; mem_if.data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nxt();
      #1;
      chk($sformatf("t4_drain_%0d", i), inst_if.data_ok, 1);
    end
    nxt();
    #1;
    chk("t4_stray_inst_ok", inst_if.data_ok, 0);
    chk("t4_stray_data_ok", data_if.data_ok, 0);

    // 5: data, inst, data accepts routed back in order
    nxt();
    mem_if.data_ok = 0; mem_if.addr_ok = 1; data_if.req = 1;
    #1;
    chk("t5_acc0", data_if.addr_ok, 1);
    nxt();
    data_if.req = 0; inst_if.req = 1;
    #1;
    chk("t5_acc1", inst_if.addr_ok, 1);
    nxt();
    inst_if.req = 0; data_if.req = 1;
    #1;
    chk("t5_acc2", data_if.addr_ok, 1);
    nxt();
    data_if.req = 0; mem_if.addr_ok = 0; mem_if.data_ok = 1; mem_if.rdata = 32'hA;
    #1;
    chk("t5_r0_data_ok", data_if.data_ok, 1);
    chk("t5_r0_rdata",   data_if.rdata,   32'hA);
    chk("t5_r0_inst_ok", inst_if.data_ok, 0);
    nxt();
    mem_if.rdata = 32'hB;
    #1;
    chk("t5_r1_inst_ok", inst_if.data_ok, 1);
    chk("t5_r1_rdata",   inst_if.rdata,   32'hB);
    chk("t5_r1_drdata",  data_if.rdata,   32'h0);
    nxt();
    mem_if.rdata = 32'hC;
    #1;
    chk("t5_r2_data_ok", data_if.data_ok, 1);
    chk("t5_r2_rdata",   data_if.rdata,   32'hC);
    chk("t5_r2_inst_ok", inst_if.data_ok, 0);

    // 6: reset with two outstanding, stray responses afterwards are dropped
    nxt();
    mem_if.data_ok = 0; mem_if.rdata = 0; mem_if.addr_ok = 1; inst_if.req = 1;
    nxt();
    nxt();
    resetn = 0; mem_if.data_ok = 1; mem_if.rdata = 32'h77;
    #1;
    chk("t6_rst_mem_req", mem_if.req,      0);
    chk("t6_rst_inst_ok", inst_if.data_ok, 0);
    nxt();
    resetn = 1; inst_if.req = 0; mem_if.addr_ok = 0;
    #1;
    chk("t6_stray0_inst_ok", inst_if.data_ok, 0);
    chk("t6_stray0_data_ok", data_if.data_ok, 0);
    nxt();
    #1;
    chk("t6_stray1_inst_ok", inst_if.data_ok, 0);
    nxt();
    mem_if.data_ok = 0; mem_if.addr_ok = 1; data_if.req = 1;
    #1;
    chk("t6_post_acc", data_if.addr_ok, 1);
    nxt();
    data_if.req = 0; mem_if.addr_ok = 0; mem_if.data_ok = 1; mem_if.rdata = 32'h99;
    #1;
    chk("t6_post_data_ok", data_if.data_ok, 1);
    chk("t6_post_rdata",   data_if.rdata,   32'h99);
    chk("t6_post_inst_ok", inst_if.data_ok, 0);
    nxt();
    mem_if.data_ok = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
